// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
// Holds the FSM state encoding, RV32I load/store funct3 codes and legality checks.
package lsu_pkg;

    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_DATA_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_unsupported(input logic write, input logic [2:0] funct3);
        if (write) return funct3 > F3_W;
        return funct3 inside {3'b011, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller (master)
// and the data memory (slave).
interface dmem_access_ctrl_if
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
);

    logic                 dm_req;
    logic [ADDR_BITS-1:0] dm_addr;
    logic [3:0]           dm_we;
    logic [DATA_BITS-1:0] dm_wdata;
    logic                 dm_gnt;
    logic                 dm_rvalid;
    logic [DATA_BITS-1:0] dm_rdata;

    modport master (
        output dm_req, dm_addr, dm_we, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_addr, dm_we, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );

endinterface

// File: rtl/dmem_load_align.sv
// Combinational load-data extraction: picks the byte/halfword addressed by the
// byte offset and sign- or zero-extends it according to funct3.
module dmem_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            F3_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-side controller: runs one data-memory transaction per load/store,
// stalls the pipeline meanwhile and delivers aligned load data with a done pulse.
module dmem_access_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 mem_req_valid,
    input  logic                 mem_req_write,
    input  logic [2:0]           mem_req_funct3,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [DATA_BITS-1:0] mem_req_wdata,

    output logic                 mem_stall,
    output logic                 mem_done,
    output logic [DATA_BITS-1:0] mem_rdata,
    output logic                 mem_exc,

    dmem_access_ctrl_if.master   dm
);

    state_e               r_state;
    logic                 r_write;
    logic [2:0]           r_funct3;
    logic [1:0]           r_off;
    logic                 r_dm_req;
    logic [ADDR_BITS-1:0] r_dm_addr;
    logic [3:0]           r_dm_we;
    logic [DATA_BITS-1:0] r_dm_wdata;
    logic                 r_done;
    logic                 r_exc;
    logic [DATA_BITS-1:0] r_rdata;

    logic [1:0]           w_off;
    logic                 w_illegal;
    logic                 w_resp;
    logic [3:0]           w_we;
    logic [DATA_BITS-1:0] w_wdata;
    logic [DATA_BITS-1:0] w_load_data;

    assign w_off     = mem_req_addr[1:0];
    assign w_illegal = is_unsupported(mem_req_write, mem_req_funct3) ||
                       is_misaligned(mem_req_funct3, w_off);

    // A response only counts while a transaction is on the bus; strays are dropped.
    assign w_resp = dm.dm_rvalid &&
                    ((r_state == WAIT) || ((r_state == REQ) && dm.dm_gnt));

    always_comb begin
        w_we    = '0;
        w_wdata = '0;
        if (mem_req_write) begin
            case (mem_req_funct3)
                F3_B: begin
                    w_we    = 4'b0001 << w_off;
                    w_wdata = {4{mem_req_wdata[7:0]}};
                end
                F3_H: begin
                    w_we    = 4'b0011 << {w_off[1], 1'b0};
                    w_wdata = {2{mem_req_wdata[15:0]}};
                end
                F3_W: begin
                    w_we    = 4'b1111;
                    w_wdata = mem_req_wdata;
                end
                default: begin
                    w_we    = '0;
                    w_wdata = '0;
                end
            endcase
        end
    end

    dmem_load_align u_load_align (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_word   (dm.dm_rdata),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers see pre-edge values.
        if (!rst_n) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_dm_req   <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_we    <= '0;
            r_dm_wdata <= '0;
            r_done     <= 1'b0;
            r_exc      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_req_valid) begin
                        if (w_illegal) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_exc   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state    <= REQ;
                            r_write    <= mem_req_write;
                            r_funct3   <= mem_req_funct3;
                            r_off      <= w_off;
                            r_dm_req   <= 1'b1;
                            r_dm_addr  <= {mem_req_addr[ADDR_BITS-1:2], 2'b00};
                            r_dm_we    <= w_we;
                            r_dm_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (dm.dm_gnt) begin
                        r_dm_req <= 1'b0;
                        if (!dm.dm_rvalid) r_state <= WAIT;
                    end
                end
                WAIT:    r_state <= WAIT;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Completion from either REQ (same-cycle response) or WAIT.
            if (w_resp) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_exc   <= 1'b0;
                r_rdata <= r_write ? '0 : w_load_data;
            end
        end
    end

    assign mem_stall   = mem_req_valid && (r_state != DONE);
    assign mem_done    = r_done;
    assign mem_rdata   = r_rdata;
    assign mem_exc     = r_exc;

    assign dm.dm_req   = r_dm_req;
    assign dm.dm_addr  = r_dm_addr;
    assign dm.dm_we    = r_dm_we;
    assign dm.dm_wdata = r_dm_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed and random loads/stores against
// a behavioural model, with scoreboard monitors on the bus and completion sides.
module tb_dmem_access_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } bus_t;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [2:0]  mem_req_funct3;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_exc;

    dmem_access_ctrl_if #(.ADDR_BITS(32), .DATA_BITS(32)) dm_bus ();

    dmem_access_ctrl #(.ADDR_BITS(32), .DATA_BITS(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_funct3 (mem_req_funct3),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_stall      (mem_stall),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .mem_exc        (mem_exc),
        .dm             (dm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    done_t exp_done[$];
    bus_t  exp_bus[$];

    logic [31:0] hold_rdata = '0;
    logic        hold_exc   = 1'b0;
    logic        prev_done  = 1'b0;
    logic        in_req     = 1'b0;
    bus_t        cur_bus;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (RV32I load/store semantics) ----------------
    function automatic bit ref_illegal(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
        int nbytes = 1 << f3[1:0];
        bit supported = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        if (!supported) return 1'b1;
        return (addr % nbytes) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int off   = int'(addr % 4);
        int nbits = 8 << f3[1:0];
        logic [31:0] mask;
        logic [31:0] v;
        if (nbits == 32) return word;
        mask = (32'd1 << nbits) - 32'd1;
        v = (word >> (8 * off)) & mask;
        if (!f3[2] && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_we(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes = 1 << f3[1:0];
        int lanes  = ((1 << nbytes) - 1) << (addr % 4);
        return lanes[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        int nbytes = 1 << f3[1:0];
        logic [31:0] v = '0;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
        return v;
    endfunction

    // ---------------- completion monitor ----------------
    always @(negedge clk) begin
        done_t e;
        if (mem_done) begin
            n_done++;
            check("done_single_pulse", {31'd0, prev_done}, 32'd0);
            if (exp_done.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got mem_done=1, want no completion pending at %0t", $time);
            end else begin
                e = exp_done.pop_front();
                check("mem_rdata", mem_rdata, e.rdata);
                check("mem_exc", {31'd0, mem_exc}, {31'd0, e.exc});
                hold_rdata = e.rdata;
                hold_exc   = e.exc;
            end
        end else if (rst_n) begin
            check("rdata_hold", mem_rdata, hold_rdata);
            check("exc_hold", {31'd0, mem_exc}, {31'd0, hold_exc});
        end
        prev_done = mem_done;
    end

    // ---------------- bus request monitor ----------------
    always @(negedge clk) begin
        if (dm_bus.dm_req) begin
            if (!in_req) begin
                if (exp_bus.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_req: got dm_req=1 addr 0x%08h, want no request at %0t",
                             dm_bus.dm_addr, $time);
                end else begin
                    cur_bus = exp_bus.pop_front();
                    check("dm_addr", dm_bus.dm_addr, cur_bus.addr);
                    check("dm_we", {28'd0, dm_bus.dm_we}, {28'd0, cur_bus.we});
                    if (cur_bus.we != 4'b0000) check("dm_wdata", dm_bus.dm_wdata, cur_bus.wdata);
                end
                in_req = 1'b1;
            end else begin
                check("dm_addr_stable", dm_bus.dm_addr, cur_bus.addr);
                check("dm_we_stable", {28'd0, dm_bus.dm_we}, {28'd0, cur_bus.we});
            end
        end else begin
            in_req = 1'b0;
        end
    end

    // ---------------- driver + bus responder ----------------
    task automatic do_access(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] word,
                             input int gnt_dly, input int rv_dly);
        bit    ill        = ref_illegal(wr, f3, addr);
        int    exp_lat    = ill ? 1 : (rv_dly == 0 ? 2 + gnt_dly : 2 + gnt_dly + rv_dly);
        int    lat        = -1;
        int    req_cycles = 0;
        int    since      = 0;
        bit    granted    = 1'b0;
        bit    responded  = 1'b0;
        bit    gnt_now;
        done_t d;
        bus_t  b;

        d.exc   = ill;
        d.rdata = (ill || wr) ? 32'd0 : ref_load(f3, addr, word);
        exp_done.push_back(d);
        if (!ill) begin
            b.addr  = addr & ~32'd3;
            b.we    = wr ? ref_we(f3, addr) : 4'b0000;
            b.wdata = wr ? ref_wdata(f3, wdata) : 32'd0;
            exp_bus.push_back(b);
        end

        mem_req_valid   = 1'b1;
        mem_req_write   = wr;
        mem_req_funct3  = f3;
        mem_req_addr    = addr;
        mem_req_wdata   = wdata;
        dm_bus.dm_rdata = word;

        for (int c = 0; c < 64 && lat < 0; c++) begin
            dm_bus.dm_gnt    = 1'b0;
            dm_bus.dm_rvalid = 1'b0;
            gnt_now          = 1'b0;
            if (!granted) begin
                if (dm_bus.dm_req) begin
                    if (req_cycles == gnt_dly) begin
                        dm_bus.dm_gnt = 1'b1;
                        granted       = 1'b1;
                        gnt_now       = 1'b1;
                        if (rv_dly == 0) begin
                            dm_bus.dm_rvalid = 1'b1;
                            responded        = 1'b1;
                        end
                    end
                    req_cycles++;
                end
            end else if (!responded) begin
                since++;
                if (since == rv_dly) begin
                    dm_bus.dm_rvalid = 1'b1;
                    responded        = 1'b1;
                end
            end
            @(negedge clk);
            check("mem_stall", {31'd0, mem_stall}, (c == exp_lat) ? 32'd0 : 32'd1);
            if (granted && !gnt_now) check("dm_req_after_gnt", {31'd0, dm_bus.dm_req}, 32'd0);
            if (mem_done) lat = c;
            @(posedge clk);
            #1;
        end
        dm_bus.dm_gnt    = 1'b0;
        dm_bus.dm_rvalid = 1'b0;
        mem_req_valid    = 1'b0;
        check("latency", lat, exp_lat);
    endtask

    task automatic idle_cycles(input int n);
        mem_req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_stall"}, {31'd0, mem_stall}, 32'd0);
        check({tag, "_mem_done"},  {31'd0, mem_done}, 32'd0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        check({tag, "_mem_exc"},   {31'd0, mem_exc}, 32'd0);
        check({tag, "_dm_req"},    {31'd0, dm_bus.dm_req}, 32'd0);
        check({tag, "_dm_addr"},   dm_bus.dm_addr, 32'd0);
        check({tag, "_dm_we"},     {28'd0, dm_bus.dm_we}, 32'd0);
        check({tag, "_dm_wdata"},  dm_bus.dm_wdata, 32'd0);
    endtask

    initial begin
        int done_before;
        bus_t b;

        rst_n            = 1'b0;
        mem_req_valid    = 1'b0;
        mem_req_write    = 1'b0;
        mem_req_funct3   = 3'd0;
        mem_req_addr     = 32'd0;
        mem_req_wdata    = 32'd0;
        dm_bus.dm_gnt    = 1'b0;
        dm_bus.dm_rvalid = 1'b0;
        dm_bus.dm_rdata  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(1);

        // Directed cases: zero-wait LW, sub-word loads, stores, exceptions, bus stalls.
        do_access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'h8765_4321, 0, 1);
        do_access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 0, 1);
        do_access(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 0, 1);
        do_access(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h80AA_BBCC, 0, 1);
        do_access(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h80AA_BBCC, 1, 1);
        do_access(1'b1, 3'b000, 32'h0000_0202, 32'h1234_56AB, 32'd0, 0, 1);
        do_access(1'b1, 3'b001, 32'h0000_0206, 32'h1234_56AB, 32'd0, 0, 1);
        do_access(1'b1, 3'b010, 32'h0000_0208, 32'h1234_56AB, 32'd0, 0, 1);
        do_access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'hFFFF_FFFF, 0, 1);
        do_access(1'b1, 3'b011, 32'h0000_0101, 32'h1234_56AB, 32'd0, 0, 1);
        do_access(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h0BAD_F00D, 3, 2);
        do_access(1'b0, 3'b010, 32'h0000_0304, 32'd0, 32'hCAFE_0001, 0, 0);

        // Reset while the load is outstanding in WAIT.
        b.addr  = 32'h0000_0100;
        b.we    = 4'b0000;
        b.wdata = 32'd0;
        exp_bus.push_back(b);
        mem_req_valid   = 1'b1;
        mem_req_write   = 1'b0;
        mem_req_funct3  = 3'b010;
        mem_req_addr    = 32'h0000_0100;
        dm_bus.dm_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        dm_bus.dm_gnt = 1'b1;
        @(posedge clk);
        #1;
        dm_bus.dm_gnt = 1'b0;
        done_before   = n_done;
        rst_n         = 1'b0;
        mem_req_valid = 1'b0;
        #1;
        check_all_zero("mid_reset");
        hold_rdata = 32'd0;
        hold_exc   = 1'b0;
        @(posedge clk);
        #1;
        rst_n            = 1'b1;
        dm_bus.dm_rvalid = 1'b1;
        @(posedge clk);
        #1;
        dm_bus.dm_rvalid = 1'b0;
        idle_cycles(3);
        check("no_done_after_stray_rvalid", n_done, done_before);
        do_access(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1357_9BDF, 0, 1);
        do_access(1'b0, 3'b000, 32'h0000_0401, 32'd0, 32'h1357_9BDF, 0, 1);

        // Randomized mix of legal and illegal accesses with random bus timing.
        for (int i = 0; i < 200; i++) begin
            bit          wr    = 1'($urandom_range(0, 1));
            logic [2:0]  f3    = 3'($urandom_range(0, 7));
            logic [31:0] addr  = $urandom;
            logic [31:0] wdata = $urandom;
            logic [31:0] word  = $urandom;
            if ($urandom_range(0, 3) != 0) f3 = wr ? 3'($urandom_range(0, 2)) : f3;
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
            do_access(wr, f3, addr, wdata, word, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) != 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        idle_cycles(2);
        check("exp_done_left", exp_done.size(), 32'd0);
        check("exp_bus_left", exp_bus.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
